// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller.
// The ALU and the datapath reuse these definitions.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADDU  = 3'b000,
    ALU_SUBU  = 3'b001,
    ALU_ORI   = 3'b010,
    ALU_LOAD  = 3'b011,
    ALU_STORE = 3'b100,
    ALU_BEQ   = 3'b101,
    ALU_LUI   = 3'b110
  } alu_ctr_e;

  typedef enum logic [1:0] {
    SRCB_RT   = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_SIMM = 2'b10,
    SRCB_ZIMM = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [3:0] {
    IC_ADDU,
    IC_SUBU,
    IC_ORI,
    IC_LUI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_J,
    IC_ILLEGAL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  function automatic logic is_rtype(input instr_class_e cls);
    return (cls == IC_ADDU) || (cls == IC_SUBU);
  endfunction

  function automatic logic is_mem(input instr_class_e cls);
    return (cls == IC_LW) || (cls == IC_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class
// plus the ALU operation and B-operand select used in EXEC and MEM.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o,
  output alu_ctr_e     alu_ctr_o,
  output src_b_e       alu_src_b_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cls_o       = IC_ILLEGAL;
    alu_ctr_o   = ALU_ADDU;
    alu_src_b_o = SRCB_RT;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: begin
            cls_o     = IC_ADDU;
            alu_ctr_o = ALU_ADDU;
          end
          FN_SUBU: begin
            cls_o     = IC_SUBU;
            alu_ctr_o = ALU_SUBU;
          end
          default: cls_o = IC_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        cls_o       = IC_ORI;
        alu_ctr_o   = ALU_ORI;
        alu_src_b_o = SRCB_ZIMM;
      end
      OP_LUI: begin
        cls_o       = IC_LUI;
        alu_ctr_o   = ALU_LUI;
        alu_src_b_o = SRCB_ZIMM;
      end
      OP_LW: begin
        cls_o       = IC_LW;
        alu_ctr_o   = ALU_LOAD;
        alu_src_b_o = SRCB_SIMM;
      end
      OP_SW: begin
        cls_o       = IC_SW;
        alu_ctr_o   = ALU_STORE;
        alu_src_b_o = SRCB_SIMM;
      end
      OP_BEQ: begin
        cls_o       = IC_BEQ;
        alu_ctr_o   = ALU_BEQ;
        alu_src_b_o = SRCB_RT;
      end
      OP_J:    cls_o = IC_J;
      default: cls_o = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM with
// Moore-style control outputs and a sticky illegal-instruction flag.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [2:0] alu_ctr,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] state
);

  state_e       state_q;
  logic         illegal_q;
  instr_class_e dec_cls;
  alu_ctr_e     dec_alu_ctr;
  src_b_e       dec_src_b;

  // IR is stable from DECODE onward, so decoding it continuously is safe;
  // the FSM only consults the result outside FETCH.
  mc_decode u_decode (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .cls_o       (dec_cls),
    .alu_ctr_o   (dec_alu_ctr),
    .alu_src_b_o (dec_src_b)
  );

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (dec_cls == IC_J) begin
            state_q <= S_FETCH;
          end else if (dec_cls == IC_ILLEGAL) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_cls == IC_BEQ)  state_q <= S_FETCH;
          else if (is_mem(dec_cls)) state_q <= S_MEM;
          else                      state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_rdy) state_q <= (dec_cls == IC_LW) ? S_WB : S_FETCH;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  logic     pc_we_c, ir_we_c, reg_we_c, mem_re_c, mem_we_c;
  logic     alu_src_a_c, reg_dst_c, mem_to_reg_c;
  alu_ctr_e alu_ctr_c;
  src_b_e   alu_src_b_c;
  pc_src_e  pc_src_c;

  always_comb begin
    pc_we_c      = 1'b0;
    ir_we_c      = 1'b0;
    reg_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    mem_we_c     = 1'b0;
    alu_src_a_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_ctr_c    = ALU_ADDU;
    alu_src_b_c  = SRCB_RT;
    pc_src_c     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        ir_we_c     = 1'b1;
        pc_we_c     = 1'b1;
        alu_src_b_c = SRCB_FOUR;
      end
      S_DECODE: begin
        if (dec_cls == IC_J) begin
          pc_we_c  = 1'b1;
          pc_src_c = PCSRC_JUMP;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_ctr_c   = dec_alu_ctr;
        alu_src_b_c = dec_src_b;
        // Branch resolves in the same cycle the ALU compares rs and rt.
        if (dec_cls == IC_BEQ) begin
          pc_src_c = PCSRC_BRANCH;
          pc_we_c  = zero;
        end
      end
      S_MEM: begin
        alu_ctr_c   = dec_alu_ctr;
        alu_src_b_c = dec_src_b;
        mem_re_c    = (dec_cls == IC_LW);
        mem_we_c    = (dec_cls == IC_SW);
      end
      S_WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = is_rtype(dec_cls);
        mem_to_reg_c = (dec_cls == IC_LW);
      end
      default: ;
    endcase
  end

  // Write enables are masked during reset so no side effect escapes
  // before the FSM has been forced back to FETCH.
  assign pc_we      = pc_we_c  & ~rst;
  assign ir_we      = ir_we_c  & ~rst;
  assign reg_we     = reg_we_c & ~rst;
  assign mem_re     = mem_re_c & ~rst;
  assign mem_we     = mem_we_c & ~rst;
  assign alu_src_a  = alu_src_a_c;
  assign reg_dst    = reg_dst_c;
  assign mem_to_reg = mem_to_reg_c;
  assign illegal    = illegal_q;
  assign alu_ctr    = alu_ctr_c;
  assign alu_src_b  = alu_src_b_c;
  assign pc_src     = pc_src_c;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: hand-computed expected values per cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_rdy;
  logic       pc_we, ir_we, reg_we, mem_re, mem_we;
  logic       alu_src_a, reg_dst, mem_to_reg, illegal;
  logic [2:0] alu_ctr, state;
  logic [1:0] alu_src_b, pc_src;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .reg_we     (reg_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .alu_src_a  (alu_src_a),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .alu_ctr    (alu_ctr),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_fetch(input string tag);
    check({tag, ".state"}, 8'(state), 8'd0);
    check({tag, ".ir_we"}, 8'(ir_we), 8'd1);
    check({tag, ".pc_we"}, 8'(pc_we), 8'd1);
    check({tag, ".srcb"}, 8'(alu_src_b), 8'b01);
    check({tag, ".aluctr"}, 8'(alu_ctr), 8'b000);
    check({tag, ".pcsrc"}, 8'(pc_src), 8'b00);
    check({tag, ".srca"}, 8'(alu_src_a), 8'd0);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_rdy = 1'b0;
    step();
    step();
    settle();
    check("rst.state", 8'(state), 8'd0);
    check("rst.wen", 8'({pc_we, ir_we, reg_we, mem_re, mem_we}), 8'd0);
    check("rst.illegal", 8'(illegal), 8'd0);

    rst = 1'b0;
    settle();
    check_fetch("addu.fetch");

    // addu: 0,1,2,4,0
    step(); opcode = 6'b000000; funct = 6'b100001; settle();
    check("addu.dec.state", 8'(state), 8'd1);
    check("addu.dec.wen", 8'({pc_we, ir_we, reg_we, mem_re, mem_we}), 8'd0);
    step(); settle();
    check("addu.exec.state", 8'(state), 8'd2);
    check("addu.exec.aluctr", 8'(alu_ctr), 8'b000);
    check("addu.exec.srcb", 8'(alu_src_b), 8'b00);
    check("addu.exec.srca", 8'(alu_src_a), 8'd1);
    step(); settle();
    check("addu.wb.state", 8'(state), 8'd4);
    check("addu.wb.regwe", 8'(reg_we), 8'd1);
    check("addu.wb.regdst", 8'(reg_dst), 8'd1);
    check("addu.wb.memtoreg", 8'(mem_to_reg), 8'd0);
    step(); settle();
    check("addu.done.state", 8'(state), 8'd0);

    // lw with 3 stall cycles; a J opcode on the bus during FETCH is ignored
    opcode = 6'b000010; settle();
    check_fetch("lw.fetch");
    step(); opcode = 6'b100011; funct = 6'd0; settle();
    check("lw.dec.state", 8'(state), 8'd1);
    check("lw.dec.pcwe", 8'(pc_we), 8'd0);
    step(); settle();
    check("lw.exec.aluctr", 8'(alu_ctr), 8'b011);
    check("lw.exec.srcb", 8'(alu_src_b), 8'b10);
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      check("lw.stall.state", 8'(state), 8'd3);
      check("lw.stall.memre", 8'(mem_re), 8'd1);
      check("lw.stall.memwe", 8'(mem_we), 8'd0);
      check("lw.stall.aluctr", 8'(alu_ctr), 8'b011);
    end
    step(); mem_rdy = 1'b1; settle();
    check("lw.mem4.state", 8'(state), 8'd3);
    check("lw.mem4.memre", 8'(mem_re), 8'd1);
    step(); mem_rdy = 1'b0; settle();
    check("lw.wb.state", 8'(state), 8'd4);
    check("lw.wb.memtoreg", 8'(mem_to_reg), 8'd1);
    check("lw.wb.regdst", 8'(reg_dst), 8'd0);
    check("lw.wb.regwe", 8'(reg_we), 8'd1);
    step(); settle();
    check("lw.done.state", 8'(state), 8'd0);

    // beq taken, then zero dropping in the same EXEC cycle
    step(); opcode = 6'b000100; settle();
    check("beq1.dec.state", 8'(state), 8'd1);
    step(); zero = 1'b1; settle();
    check("beq1.exec.state", 8'(state), 8'd2);
    check("beq1.exec.pcwe", 8'(pc_we), 8'd1);
    check("beq1.exec.pcsrc", 8'(pc_src), 8'b01);
    check("beq1.exec.aluctr", 8'(alu_ctr), 8'b101);
    check("beq1.exec.srcb", 8'(alu_src_b), 8'b00);
    zero = 1'b0; settle();
    check("beq1.exec.zdrop", 8'(pc_we), 8'd0);
    step(); settle();
    check("beq1.done.state", 8'(state), 8'd0);

    // beq not taken
    step(); settle();
    step(); zero = 1'b0; settle();
    check("beq0.exec.pcwe", 8'(pc_we), 8'd0);
    check("beq0.exec.pcsrc", 8'(pc_src), 8'b01);
    step(); settle();
    check("beq0.done.state", 8'(state), 8'd0);

    // j: resolves in DECODE
    step(); opcode = 6'b000010; settle();
    check("j.dec.state", 8'(state), 8'd1);
    check("j.dec.pcwe", 8'(pc_we), 8'd1);
    check("j.dec.pcsrc", 8'(pc_src), 8'b10);
    step(); settle();
    check("j.done.state", 8'(state), 8'd0);

    // illegal opcode, then a valid ori with illegal still set
    step(); opcode = 6'b111111; settle();
    check("ill.dec.illegal", 8'(illegal), 8'd0);
    check("ill.dec.pcwe", 8'(pc_we), 8'd0);
    step(); settle();
    check("ill.fetch.state", 8'(state), 8'd0);
    check("ill.fetch.illegal", 8'(illegal), 8'd1);
    step(); opcode = 6'b001101; settle();
    step(); settle();
    check("ori.exec.aluctr", 8'(alu_ctr), 8'b010);
    check("ori.exec.srcb", 8'(alu_src_b), 8'b11);
    step(); settle();
    check("ori.wb.state", 8'(state), 8'd4);
    check("ori.wb.regdst", 8'(reg_dst), 8'd0);
    check("ori.wb.illegal", 8'(illegal), 8'd1);
    step(); settle();
    check("ori.done.illegal", 8'(illegal), 8'd1);

    // sw interrupted by reset during a MEM stall
    step(); opcode = 6'b101011; settle();
    step(); settle();
    check("sw.exec.aluctr", 8'(alu_ctr), 8'b100);
    check("sw.exec.srcb", 8'(alu_src_b), 8'b10);
    step(); settle();
    check("sw.mem.state", 8'(state), 8'd3);
    check("sw.mem.memwe", 8'(mem_we), 8'd1);
    check("sw.mem.memre", 8'(mem_re), 8'd0);
    step(); rst = 1'b1; settle();
    check("sw.rst.memwe", 8'(mem_we), 8'd0);
    step(); settle();
    check("sw.rst.state", 8'(state), 8'd0);
    check("sw.rst.wen", 8'({pc_we, ir_we, reg_we, mem_re, mem_we}), 8'd0);
    check("sw.rst.illegal", 8'(illegal), 8'd0);
    rst = 1'b0; settle();
    check("sw.post.irwe", 8'(ir_we), 8'd1);
    check_fetch("sw.post");

    // sw completing with mem_rdy already high: 4 cycles
    step(); opcode = 6'b101011; mem_rdy = 1'b1; settle();
    step(); settle();
    step(); settle();
    check("sw2.mem.memwe", 8'(mem_we), 8'd1);
    step(); mem_rdy = 1'b0; settle();
    check("sw2.done.state", 8'(state), 8'd0);

    // R-type with an unsupported funct
    step(); opcode = 6'b000000; funct = 6'b100000; settle();
    check("badfn.dec.state", 8'(state), 8'd1);
    step(); settle();
    check("badfn.fetch.state", 8'(state), 8'd0);
    check("badfn.fetch.illegal", 8'(illegal), 8'd1);

    // lui and subu ALU selections
    step(); opcode = 6'b001111; settle();
    step(); settle();
    check("lui.exec.aluctr", 8'(alu_ctr), 8'b110);
    check("lui.exec.srcb", 8'(alu_src_b), 8'b11);
    step(); settle();
    check("lui.wb.regdst", 8'(reg_dst), 8'd0);
    step(); settle();
    step(); opcode = 6'b000000; funct = 6'b100011; settle();
    step(); settle();
    check("subu.exec.aluctr", 8'(alu_ctr), 8'b001);
    check("subu.exec.srcb", 8'(alu_src_b), 8'b00);
    step(); settle();
    check("subu.wb.regdst", 8'(reg_dst), 8'd1);
    step(); settle();
    check("subu.done.state", 8'(state), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high; all state changes on the rising edge of clk.
REQ-002 SHALL have inputs: opcode 6 (IR[31:26]); funct 6 (IR[5:0]); zero 1 (ALU zero flag); mem_rdy 1 (data memory done).
REQ-003 SHALL have outputs, each 1 bit: pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_a (0 = PC, 1 = rs), reg_dst (0 = rt, 1 = rd), mem_to_reg, illegal (sticky).
REQ-004 SHALL have outputs: alu_ctr 3; alu_src_b 2 (00 rt, 01 const 4, 10 sign-ext imm, 11 zero-ext imm); pc_src 2 (00 ALU out, 01 branch target, 10 jump target); state 3 (debug).
REQ-005 SHALL drive alu_ctr with the ALU encoding: ADDU 000, SUBU 001, ORI 010, LOAD 011, STORE 100, BEQ 101, LUI 110.

Function
REQ-006 SHALL be a multi-cycle FSM with states FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4; the state output equals the current state encoding.
REQ-007 SHALL drive all outputs not listed for a state to 0 (Moore defaults), except pc_we in EXEC for BEQ (REQ-012).
REQ-008 FETCH: ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01, alu_ctr=ADDU, pc_src=00; next state DECODE.
REQ-009 DECODE: no write enables; decode opcode/funct.
- J (000010): pc_we=1, pc_src=10; next FETCH.
- Supported opcode: next EXEC.
- Anything else: illegal set to 1; next FETCH.
REQ-010 Supported instructions: addu (op 000000, funct 100001), subu (op 000000, funct 100011), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
- R-type with any other funct is illegal.
REQ-011 EXEC: alu_src_a=1.
- addu: alu_src_b=00, alu_ctr=ADDU.
- subu: alu_src_b=00, alu_ctr=SUBU.
- ori: alu_src_b=11, alu_ctr=ORI.
- lui: alu_src_b=11, alu_ctr=LUI.
- lw: alu_src_b=10, alu_ctr=LOAD.
- sw: alu_src_b=10, alu_ctr=STORE.
- beq: alu_src_b=00, alu_ctr=BEQ.
REQ-012 EXEC for beq: pc_src=01, pc_we=zero (combinational, same cycle); next FETCH.
REQ-013 EXEC next state: MEM for lw/sw; WB for addu/subu/ori/lui.
REQ-014 MEM: alu_src_b and alu_ctr held at their EXEC values; mem_re=1 for lw, mem_we=1 for sw.
- Remain in MEM while mem_rdy=0.
- When mem_rdy=1: lw goes to WB, sw goes to FETCH.
REQ-015 WB: reg_we=1.
- reg_dst=1 for R-type, 0 otherwise.
- mem_to_reg=1 for lw, 0 otherwise.
- Next state FETCH.
REQ-016 Latency in cycles: j 2, beq 3, addu/subu/ori/lui 4, sw 4+N, lw 5+N, where N is the number of MEM cycles with mem_rdy=0.
REQ-017 opcode/funct are sampled only in DECODE, EXEC, MEM and WB (IR is stable after FETCH); changes during FETCH have no effect.
REQ-018 illegal remains 1 until rst; the FSM continues fetching after an illegal opcode.

Reset
REQ-019 rst=1 at a clock edge SHALL force state to FETCH and illegal to 0, in any state including MEM mid-stall.
REQ-020 While rst=1, all write enables (pc_we, ir_we, reg_we, mem_we, mem_re) SHALL be 0.
REQ-021 The first FETCH outputs SHALL appear in the first cycle after rst deasserts.

Structure
REQ-022 A shared package SHALL hold: alu_ctr encodings, opcode/funct constants, state encodings, and the alu_src_b/pc_src select encodings, for reuse by the ALU and datapath.
REQ-023 A combinational decoder sub-module mc_decode SHALL map opcode/funct to an instruction class plus its EXEC alu_ctr/alu_src_b; mc_ctrl holds the FSM.

Verification
REQ-024 addu (op 0, funct 100001) after reset -> states 0,1,2,4,0; EXEC alu_ctr=000, alu_src_b=00; WB reg_we=1, reg_dst=1.
REQ-025 lw with mem_rdy low for 3 cycles -> MEM held 4 cycles with mem_re=1; WB mem_to_reg=1; total 8 cycles.
REQ-026 beq with zero=1 -> EXEC pc_we=1, pc_src=01.
- Repeat with zero=0 -> pc_we=0; both cases return to FETCH after 3 cycles.
REQ-027 opcode 111111 -> illegal=1 after DECODE; FETCH next cycle.
- illegal stays 1 through a following valid ori; cleared only by rst.
REQ-028 rst asserted during a sw MEM stall -> next state FETCH, mem_we=0 while rst=1; first post-reset cycle has ir_we=1.
REQ-029 j -> pc_we=1, pc_src=10 in DECODE; FETCH next, 2-cycle latency.
